// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable inclusive limit, parallel load, wrap or saturate mode.
// Latency: one cycle from inputs to count/bound; at_max/at_zero follow count combinationally.
// Backpressure: none; en advances one step per cycle, load overrides en, otherwise count holds.
module updown_counter_mod #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             bound,
  output logic             ovf_sticky,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             bound_q, bound_d;
  logic             ovf_q,   ovf_d;
  logic             hit;

  // Next-state: load beats en; a boundary step either wraps or clamps.
  always_comb begin
    count_d = count_q;
    hit     = 1'b0;
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q >= max_val) begin
          hit     = 1'b1;
          count_d = sat_mode ? max_val : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        // A lowered limit pulls the count back in range without flagging a boundary.
        if (count_q > max_val) begin
          count_d = max_val;
        end else if (count_q == '0) begin
          hit     = 1'b1;
          count_d = sat_mode ? '0 : max_val;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    bound_d = hit;
    // Setting wins over a same-edge clear so no boundary event is lost.
    ovf_d   = hit | (ovf_q & ~clr_ovf);
  end

  // State registers; reset takes effect immediately and drops any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      bound_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bound_q <= bound_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign bound      = bound_q;
  assign ovf_sticky = ovf_q;
  assign at_max     = (count_q >= max_val);
  assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod (WIDTH=8, RESET_VAL=0).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, sat_mode, load, clr_ovf;
  logic [7:0] max_val, load_val;
  logic [7:0] count;
  logic       bound, ovf_sticky, at_max, at_zero;

  int checks = 0;
  int errors = 0;

  updown_counter_mod #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .sat_mode  (sat_mode),
    .max_val   (max_val),
    .load      (load),
    .load_val  (load_val),
    .clr_ovf   (clr_ovf),
    .count     (count),
    .bound     (bound),
    .ovf_sticky(ovf_sticky),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_c(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
    clr_ovf = 1'b0; max_val = 8'd9; load_val = 8'd0;
    @(negedge clk);
    chk_c("rst_count", count, 8'd0);
    chk_b("rst_bound", bound, 1'b0);
    chk_b("rst_ovf", ovf_sticky, 1'b0);
    chk_b("rst_at_zero", at_zero, 1'b1);
    chk_b("rst_at_max", at_max, 1'b0);
    rst_n = 1'b1;

    // Build up some state, then reset between edges.
    load = 1'b1; load_val = 8'd9; tick();
    chk_c("load9", count, 8'd9);
    chk_b("load9_at_max", at_max, 1'b1);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk_c("pre_wrap", count, 8'd0);
    chk_b("pre_wrap_bound", bound, 1'b1);
    chk_b("pre_wrap_ovf", ovf_sticky, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 8'd5; tick();
    chk_c("load5", count, 8'd5);
    chk_b("load5_bound", bound, 1'b0);
    chk_b("load_keeps_ovf", ovf_sticky, 1'b1);
    load = 1'b0; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_c("async_rst_count", count, 8'd0);
    chk_b("async_rst_bound", bound, 1'b0);
    chk_b("async_rst_ovf", ovf_sticky, 1'b0);
    repeat (3) tick();
    chk_c("rst_hold_count", count, 8'd0);
    chk_b("rst_hold_ovf", ovf_sticky, 1'b0);
    rst_n = 1'b1; en = 1'b0; tick();
    chk_c("rst_release", count, 8'd0);

    // Wrap up through max_val=9 for 12 steps.
    max_val = 8'd9; sat_mode = 1'b0; up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_c("wrap_up_count", count, 8'(i % 10));
      chk_b("wrap_up_bound", bound, (i == 10));
    end
    chk_b("wrap_up_ovf", ovf_sticky, 1'b1);
    en = 1'b0;

    // Wrap down from 0 and sticky clear behaviour.
    load = 1'b1; load_val = 8'd0; tick();
    load = 1'b0; clr_ovf = 1'b1; tick();
    chk_b("clr_ovf", ovf_sticky, 1'b0);
    chk_c("clr_hold", count, 8'd0);
    clr_ovf = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk_c("wrap_down", count, 8'd9);
    chk_b("wrap_down_bound", bound, 1'b1);
    chk_b("wrap_down_ovf", ovf_sticky, 1'b1);
    up = 1'b1; clr_ovf = 1'b1; tick();
    chk_c("clr_vs_hit_count", count, 8'd0);
    chk_b("clr_vs_hit_bound", bound, 1'b1);
    chk_b("clr_vs_hit_ovf", ovf_sticky, 1'b1);
    en = 1'b0; tick();
    chk_b("clr_after", ovf_sticky, 1'b0);
    chk_b("idle_bound", bound, 1'b0);
    clr_ovf = 1'b0;

    // Saturate up at 200 and down at 0.
    sat_mode = 1'b1; max_val = 8'd200; load = 1'b1; load_val = 8'd198; tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(); chk_c("sat_up1", count, 8'd199); chk_b("sat_up1_b", bound, 1'b0);
    tick(); chk_c("sat_up2", count, 8'd200); chk_b("sat_up2_b", bound, 1'b0);
    tick(); chk_c("sat_up3", count, 8'd200); chk_b("sat_up3_b", bound, 1'b1);
    tick(); chk_c("sat_up4", count, 8'd200); chk_b("sat_up4_b", bound, 1'b1);
    chk_b("sat_at_max", at_max, 1'b1);
    chk_b("sat_ovf", ovf_sticky, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 8'd1; tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick(); chk_c("sat_dn1", count, 8'd0); chk_b("sat_dn1_b", bound, 1'b0);
    tick(); chk_c("sat_dn2", count, 8'd0); chk_b("sat_dn2_b", bound, 1'b1);
    chk_b("sat_at_zero", at_zero, 1'b1);

    // Load clamping and load priority over en.
    en = 1'b0; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    load = 1'b1; load_val = 8'd250; tick();
    chk_c("load_clamp", count, 8'd200);
    chk_b("load_clamp_b", bound, 1'b0);
    en = 1'b1; up = 1'b1; load_val = 8'd7; tick();
    chk_c("load_wins", count, 8'd7);
    chk_b("load_wins_b", bound, 1'b0);
    chk_b("load_no_ovf", ovf_sticky, 1'b0);

    // Hold with en=0 while other controls wiggle.
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = i[0]; sat_mode = i[1]; max_val = 8'(3 + i);
      tick();
    end
    chk_c("hold_count", count, 8'd7);
    chk_b("hold_bound", bound, 1'b0);

    // Lowered limit and max_val=0.
    sat_mode = 1'b1; max_val = 8'd200; load = 1'b1; load_val = 8'd50; tick();
    load = 1'b0; max_val = 8'd20; en = 1'b1; up = 1'b0; tick();
    chk_c("lower_max", count, 8'd20);
    chk_b("lower_max_b", bound, 1'b0);
    tick();
    chk_c("lower_max_step", count, 8'd19);
    max_val = 8'd0; up = 1'b1; tick();
    chk_c("max0_a", count, 8'd0); chk_b("max0_a_b", bound, 1'b1);
    tick();
    chk_c("max0_b", count, 8'd0); chk_b("max0_b_b", bound, 1'b1);
    sat_mode = 1'b0; up = 1'b0; tick();
    chk_c("max0_c", count, 8'd0); chk_b("max0_c_b", bound, 1'b1);
    chk_b("max0_at_max", at_max, 1'b1);
    chk_b("max0_at_zero", at_zero, 1'b1);
    en = 1'b0; tick();
    chk_b("max0_idle_b", bound, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
